// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared FSM states, default sizing and lane count for data_mem_responder
package dmem_pkg;
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  localparam int DEF_DEPTH_BYTES = 1024;
  localparam int DEF_LATENCY = 2;
  localparam int LANES = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake between requester (master) and responder (slave)
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: word-addressed storage built from byte lanes; sync write per lane, combinational read
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic [AW-1:0]        addr,
  input  logic [8*LANES-1:0]   wdata,
  output logic [8*LANES-1:0]   rdata
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [WORDS];
    always_ff @(posedge clk)
      if (we[l]) mem[addr] <= wdata[8*l+:8];
    assign rdata[8*l+:8] = mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding memory responder with self-initialising RAM and fixed response latency
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int LATENCY = DEF_LATENCY
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam int WORDS = DEPTH_BYTES / LANES;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t state, state_d;
  logic [IW-1:0] init_cnt;
  logic [3:0] lat_cnt;
  logic [31:0] rdata_q;
  logic err_q;
  logic accept, err;
  logic [LANES-1:0] ram_we;
  logic [IW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  assign accept = bus.req_valid && state == IDLE;
  assign err = bus.req_addr[1:0] != 2'b00 || bus.req_addr >= 32'(DEPTH_BYTES);
  // INIT sweeps every word so that byte i holds i[7:0]
  always_comb begin
    ram_addr = state == INIT ? init_cnt : bus.req_addr[IW+1:2];
    ram_we = state == INIT ? '1 : (accept && bus.req_we && !err) ? bus.req_wstrb : '0;
    for (int k = 0; k < LANES; k++)
      ram_wdata[8*k+:8] = state == INIT ? 8'({init_cnt, 2'(k)}) : bus.req_wdata[8*k+:8];
  end
  dmem_byte_ram #(.WORDS(WORDS), .AW(IW)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  always_comb begin
    state_d = state;
    unique case (state)
      INIT: state_d = init_cnt == IW'(WORDS - 1) ? IDLE : INIT;
      IDLE: state_d = accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
      WAIT: state_d = lat_cnt == 4'(LATENCY - 1) ? RESP : WAIT;
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_cnt <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      init_cnt <= state == INIT ? init_cnt + 1'b1 : '0;
      lat_cnt <= state == WAIT ? lat_cnt + 4'd1 : 4'd0;
      if (accept) begin
        err_q <= err;
        rdata_q <= (err || bus.req_we) ? 32'd0 : ram_rdata;
      end
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = state == RESP ? rdata_q : 32'd0;
  assign bus.rsp_err = state == RESP && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table, corner sequences and randomized traffic against a byte-array model
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();
  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [1024];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void model_init();
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
  endfunction
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rd, output logic e);
    e = addr[1:0] != 2'b00 || addr >= 32'd1024;
    rd = 32'd0;
    if (!e)
      for (int k = 0; k < 4; k++)
        if (we && wstrb[k]) mem[addr+k] = wdata[8*k+:8];
        else if (!we) rd[8*k+:8] = mem[addr+k];
  endtask
  task automatic wait_ready(output int n, output int spur);
    n = 0;
    spur = 0;
    while (!bus.req_ready && n < 5000) begin
      if (bus.rsp_valid) spur++;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int hold,
                     output logic [31:0] rd, output logic e, output int lat);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    e = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("hold_stable", {bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.rsp_rdata[28:0]},
          {1'b1, e, 1'b0, rd[28:0]});
      chk("hold_rdata", bus.rsp_rdata, rd);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("ready_after_rsp", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
  endtask
  initial begin
    vec_t tbl[$];
    logic [31:0] rd, mrd;
    logic e, me;
    int lat, n, spur;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_we = 1'b0;
    bus0.req_addr = '0;
    bus0.req_wdata = '0;
    bus0.req_wstrb = '0;
    bus0.rsp_ready = 1'b1;
    model_init();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus0.req_ready, bus0.rsp_valid}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    wait_ready(n, spur);
    chk("init_cycles", n, 32'd256);
    chk("init_no_rsp", spur, 32'd0);
    chk("lat0_ready", {31'd0, bus0.req_ready}, 32'd1);
    // LATENCY=0 back-to-back: each iteration spans exactly two cycles
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'(i * 'h84);
      chk("b2b_ready", {31'd0, bus0.req_ready}, 32'd1);
      bus0.req_addr = a;
      @(negedge clk);
      chk("b2b_valid", {30'd0, bus0.rsp_valid, bus0.req_ready}, 32'd2);
      chk("b2b_rdata", bus0.rsp_rdata, {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]});
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    tbl.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 0, 32'h13121110, 1'b0});
    tbl.push_back('{1'b1, 32'h020, 32'hDEADBEEF, 4'b0101, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h020, 32'h0, 4'h0, 0, 32'h23AD21EF, 1'b0});
    tbl.push_back('{1'b0, 32'h022, 32'h0, 4'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h022, 32'h55555555, 4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h020, 32'h0, 4'h0, 0, 32'h23AD21EF, 1'b0});
    tbl.push_back('{1'b1, 32'h030, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h030, 32'h0, 4'h0, 1, 32'h33323130, 1'b0});
    tbl.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 5, 32'hFFFEFDFC, 1'b0});
    tbl.push_back('{1'b1, 32'h3FC, 32'h11223344, 4'hF, 2, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'h11223344, 1'b0});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 32'h0, 1'b1});
    foreach (tbl[i]) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].hold, rd, e, lat);
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, mrd, me);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd3);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
    end
    for (int i = 0; i < 200; i++) begin
      logic w;
      logic [31:0] a, d;
      logic [3:0] s;
      w = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 'h4FF)) : 32'($urandom_range(0, 255) * 4);
      d = $urandom;
      s = 4'($urandom);
      txn(w, a, d, s, $urandom_range(0, 3), rd, e, lat);
      model(w, a, d, s, mrd, me);
      chk("rnd_latency", lat, 32'd3);
      chk($sformatf("rnd_rdata@%h", a), rd, mrd);
      chk($sformatf("rnd_err@%h", a), {31'd0, e}, {31'd0, me});
    end
    // reset while the store response is still pending
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 32'h040;
    bus.req_wdata = 32'hAAAAAAAA;
    bus.req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("wait_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    spur = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.req_ready || bus.rsp_err || bus.rsp_rdata != 0) spur++;
    end
    chk("rst_mid_outputs", spur, 32'd0);
    rst = 1'b0;
    wait_ready(n, spur);
    chk("reinit_cycles", n, 32'd256);
    chk("reinit_no_rsp", spur, 32'd0);
    model_init();
    txn(1'b0, 32'h040, 32'h0, 4'h0, 0, rd, e, lat);
    chk("reinit_rdata", rd, 32'h43424140);
    chk("reinit_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, e, lat);
    chk("reinit_top_rdata", rd, 32'hFFFEFDFC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
